// File: rtl/led_matrix_scan_if.sv
// Frame handoff bus from the game core to the LED matrix scanner.
// A frame moves across on a clock edge where frame_valid and frame_ready are both high.
interface led_matrix_scan_if;
    logic [63:0] pix;          // bit 8*y+x = row y, column x
    logic        frame_valid;  // pix holds a new frame
    logic        frame_ready;  // scanner can take a frame

    // Game core side
    modport master (
        output pix,
        output frame_valid,
        input  frame_ready
    );

    // Scanner side
    modport slave (
        input  pix,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver.
// An incoming frame is held in a pending buffer. It is copied into the display
// buffer only at a frame boundary (the edge that starts driving row 0), so a
// displayed frame never tears. Each row gets BLANK all-off cycles and then
// DWELL driven cycles. The blank cycles keep ghost images off the panel.
module led_matrix_scan #(
    parameter int DWELL = 4,   // cycles each row is driven (>= 1)
    parameter int BLANK = 1    // all-off cycles before each row (>= 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_matrix_scan_if.slave     bus,
    output logic [7:0]           row_sel,
    output logic [7:0]           col,
    output logic [2:0]           row_idx,
    output logic                 frame_swap
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    row_q, row_d;
    logic [63:0]   disp_q, disp_d;
    logic [63:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [7:0]    row_sel_q, row_sel_d;
    logic [7:0]    col_q, col_d;
    logic          frame_swap_q, frame_swap_d;

    // Next-state logic: the scan sequencer, the frame swap at the row-0 boundary,
    // and the handshake capture. The outputs are computed from the next state so
    // that they come straight from flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        row_d        = row_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        frame_swap_d = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    // Frame boundary. The swap uses the registered pend_full, so a
                    // frame accepted on this same edge waits for the next frame.
                    if (row_q == 3'd0 && pend_full_q) begin
                        disp_d       = pend_q;
                        pend_full_d  = 1'b0;
                        frame_swap_d = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    row_d   = row_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // A capture and a swap never happen on the same edge. A swap needs
        // pend_full = 1, and a capture needs pend_full = 0.
        if (bus.frame_valid && !pend_full_q) begin
            pend_d      = bus.pix;
            pend_full_d = 1'b1;
        end

        row_sel_d = 8'h00;
        col_d     = 8'h00;
        if (state_d == ST_DRIVE) begin
            row_sel_d = 8'h01 << row_d;
            col_d     = disp_d[{row_d, 3'b000} +: 8];
        end
    end

    // State registers. Reset is asynchronous, so the panel goes dark immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            row_q        <= 3'd0;
            disp_q       <= 64'h0;
            pend_q       <= 64'h0;
            pend_full_q  <= 1'b0;
            row_sel_q    <= 8'h00;
            col_q        <= 8'h00;
            frame_swap_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            row_sel_q    <= row_sel_d;
            col_q        <= col_d;
            frame_swap_q <= frame_swap_d;
        end
    end

    assign bus.frame_ready = !pend_full_q;
    assign row_sel         = row_sel_q;
    assign col             = col_q;
    assign row_idx         = row_q;
    assign frame_swap      = frame_swap_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan.
// It runs a default-parameter instance and a DWELL=1/BLANK=1 instance.
// Cycle n is the state presented to clock edge n after reset release.
module tb_led_matrix_scan;

    logic clk;
    logic rst_n;
    logic [7:0] rs1, col1, rs2, col2;
    logic [2:0] idx1, idx2;
    logic       sw1, sw2;

    led_matrix_scan_if bus1 ();
    led_matrix_scan_if bus2 ();

    led_matrix_scan #(.DWELL(4), .BLANK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .row_sel(rs1), .col(col1), .row_idx(idx1), .frame_swap(sw1)
    );

    led_matrix_scan #(.DWELL(1), .BLANK(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .row_sel(rs2), .col(col2), .row_idx(idx2), .frame_swap(sw2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic        valid;
        logic [63:0] pix;
        logic [7:0]  rs;
        logic [7:0]  col;
        logic [2:0]  idx;
        logic        swap;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] FR_D    = 64'h0000_0000_0000_0018;
    localparam logic [63:0] FR_DIAG = 64'h8040_2010_0804_0201;
    localparam logic [63:0] FR_A    = 64'h0F0E_0D0C_0B0A_09A5;
    localparam logic [63:0] FR_B    = 64'hF1E2_D3C4_B5A6_973C;
    localparam logic [63:0] FR_C    = 64'h0102_0408_1020_4080;
    localparam logic [63:0] FR_E    = 64'h5A69_7887_96A5_B4C3;
    localparam logic [63:0] FR_Z    = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic vec_t mk(int c, logic v, logic [63:0] p, logic [7:0] rs,
                                logic [7:0] cl, logic [2:0] ix, logic sw, logic rd);
        vec_t t;
        t.cyc = c; t.valid = v; t.pix = p; t.rs = rs;
        t.col = cl; t.idx = ix; t.swap = sw; t.rdy = rd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // Model of the default instance: 5-cycle rows, 40-cycle frame
    task automatic check_scan(input logic [63:0] f, input logic rdy);
        int p, r;
        logic [7:0] ers, ecol;
        p = cyc % 40;
        r = p / 5;
        ers  = 8'h00;
        ecol = 8'h00;
        if ((p % 5) != 0) begin
            ers  = 8'(1 << r);
            ecol = f[8*r +: 8];
        end
        chk("scan_row_sel", {56'h0, rs1}, {56'h0, ers});
        chk("scan_col", {56'h0, col1}, {56'h0, ecol});
        chk("scan_row_idx", {61'h0, idx1}, 64'(r));
        chk("scan_swap", {63'h0, sw1}, 64'h0);
        chk("scan_ready", {63'h0, bus1.frame_ready}, {63'h0, rdy});
    endtask

    // Model of the DWELL=1/BLANK=1 instance: 2-cycle rows, 16-cycle frame
    task automatic check_scan2(input logic [63:0] f, input logic rdy);
        int p, r;
        logic [7:0] ers, ecol;
        p = cyc % 16;
        r = p / 2;
        ers  = 8'h00;
        ecol = 8'h00;
        if ((p % 2) != 0) begin
            ers  = 8'(1 << r);
            ecol = f[8*r +: 8];
        end
        chk("fast_row_sel", {56'h0, rs2}, {56'h0, ers});
        chk("fast_col", {56'h0, col2}, {56'h0, ecol});
        chk("fast_row_idx", {61'h0, idx2}, 64'(r));
        chk("fast_swap", {63'h0, sw2}, 64'h0);
        chk("fast_ready", {63'h0, bus2.frame_ready}, {63'h0, rdy});
    endtask

    initial begin
        rst_n = 1'b0;
        bus1.pix = 64'h0; bus1.frame_valid = 1'b0;
        bus2.pix = 64'h0; bus2.frame_valid = 1'b0;

        // Reset held: both instances are dark and ready
        tick();
        tick();
        chk("rst_row_sel", {56'h0, rs1}, 64'h0);
        chk("rst_col", {56'h0, col1}, 64'h0);
        chk("rst_row_idx", {61'h0, idx1}, 64'h0);
        chk("rst_swap", {63'h0, sw1}, 64'h0);
        chk("rst_ready", {63'h0, bus1.frame_ready}, 64'h1);
        chk("rst2_row_sel", {56'h0, rs2}, 64'h0);
        chk("rst2_ready", {63'h0, bus2.frame_ready}, 64'h1);
        $display("reset hold: row_sel=%0h col=%0h ready=%0b", rs1, col1, bus1.frame_ready);

        // Single frame, then the diagonal row-mapping frame
        vecs.push_back(mk(  0, 0, 64'h0,   8'h00, 8'h00, 3'd0, 0, 1));
        vecs.push_back(mk(  1, 0, 64'h0,   8'h01, 8'h00, 3'd0, 0, 1));
        vecs.push_back(mk(  2, 1, FR_D,    8'h01, 8'h00, 3'd0, 0, 1));
        vecs.push_back(mk(  3, 0, 64'h0,   8'h01, 8'h00, 3'd0, 0, 0));
        vecs.push_back(mk(  5, 0, 64'h0,   8'h00, 8'h00, 3'd1, 0, 0));
        vecs.push_back(mk(  6, 0, 64'h0,   8'h02, 8'h00, 3'd1, 0, 0));
        vecs.push_back(mk( 36, 0, 64'h0,   8'h80, 8'h00, 3'd7, 0, 0));
        vecs.push_back(mk( 39, 0, 64'h0,   8'h80, 8'h00, 3'd7, 0, 0));
        vecs.push_back(mk( 40, 0, 64'h0,   8'h00, 8'h00, 3'd0, 0, 0));
        vecs.push_back(mk( 41, 0, 64'h0,   8'h01, 8'h18, 3'd0, 1, 1));
        vecs.push_back(mk( 42, 0, 64'h0,   8'h01, 8'h18, 3'd0, 0, 1));
        vecs.push_back(mk( 44, 0, 64'h0,   8'h01, 8'h18, 3'd0, 0, 1));
        vecs.push_back(mk( 45, 0, 64'h0,   8'h00, 8'h00, 3'd1, 0, 1));
        vecs.push_back(mk( 46, 0, 64'h0,   8'h02, 8'h00, 3'd1, 0, 1));
        vecs.push_back(mk( 76, 0, 64'h0,   8'h80, 8'h00, 3'd7, 0, 1));
        vecs.push_back(mk( 80, 0, 64'h0,   8'h00, 8'h00, 3'd0, 0, 1));
        vecs.push_back(mk( 81, 1, FR_DIAG, 8'h01, 8'h18, 3'd0, 0, 1));
        vecs.push_back(mk( 82, 0, 64'h0,   8'h01, 8'h18, 3'd0, 0, 0));
        vecs.push_back(mk(120, 0, 64'h0,   8'h00, 8'h00, 3'd0, 0, 0));
        vecs.push_back(mk(121, 0, 64'h0,   8'h01, 8'h01, 3'd0, 1, 1));

        // Release reset between edges, so the next edge is edge 0
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < vecs[i].cyc) begin
                tick();
                bus1.frame_valid = 1'b0;
            end
            chk("vec_row_sel", {56'h0, rs1}, {56'h0, vecs[i].rs});
            chk("vec_col", {56'h0, col1}, {56'h0, vecs[i].col});
            chk("vec_row_idx", {61'h0, idx1}, {61'h0, vecs[i].idx});
            chk("vec_swap", {63'h0, sw1}, {63'h0, vecs[i].swap});
            chk("vec_ready", {63'h0, bus1.frame_ready}, {63'h0, vecs[i].rdy});
            $display("vec %0d cyc=%0d row_sel=%0h col=%0h idx=%0d swap=%0b ready=%0b",
                     i, cyc, rs1, col1, idx1, sw1, bus1.frame_ready);
            bus1.pix = vecs[i].pix;
            bus1.frame_valid = vecs[i].valid;
        end
        tick();
        bus1.frame_valid = 1'b0;
        check_scan(FR_DIAG, 1'b1);

        // Row mapping: the diagonal frame drives col = 1<<r on row r
        while (cyc < 160) begin
            tick();
            check_scan(FR_DIAG, 1'b1);
        end
        $display("row mapping frame done at cyc=%0d", cyc);

        // Backpressure: A is accepted, and B is held valid until A is swapped in
        bus1.pix = FR_A;
        bus1.frame_valid = 1'b1;
        tick();
        chk("bp_a_accept_ready", {63'h0, bus1.frame_ready}, 64'h0);
        chk("bp_a_no_swap", {63'h0, sw1}, 64'h0);
        bus1.pix = FR_B;
        while (cyc < 200) begin
            tick();
            check_scan(FR_DIAG, 1'b0);
        end
        tick();
        chk("bp_a_swap", {63'h0, sw1}, 64'h1);
        chk("bp_a_col", {56'h0, col1}, {56'h0, FR_A[7:0]});
        chk("bp_a_ready", {63'h0, bus1.frame_ready}, 64'h1);
        $display("backpressure: A visible cyc=%0d col=%0h", cyc, col1);
        tick();
        chk("bp_b_accept_ready", {63'h0, bus1.frame_ready}, 64'h0);
        chk("bp_b_col_still_a", {56'h0, col1}, {56'h0, FR_A[7:0]});
        bus1.frame_valid = 1'b0;
        while (cyc < 240) begin
            tick();
            check_scan(FR_A, 1'b0);
        end
        tick();
        chk("bp_b_swap", {63'h0, sw1}, 64'h1);
        chk("bp_b_col", {56'h0, col1}, {56'h0, FR_B[7:0]});
        chk("bp_b_ready", {63'h0, bus1.frame_ready}, 64'h1);
        $display("backpressure: B visible cyc=%0d col=%0h", cyc, col1);

        // A frame accepted on the row-0 boundary edge is too late for that frame
        while (cyc < 280) begin
            tick();
            check_scan(FR_B, 1'b1);
        end
        bus1.pix = FR_C;
        bus1.frame_valid = 1'b1;
        tick();
        bus1.frame_valid = 1'b0;
        chk("late_no_swap", {63'h0, sw1}, 64'h0);
        chk("late_col_old", {56'h0, col1}, {56'h0, FR_B[7:0]});
        chk("late_ready", {63'h0, bus1.frame_ready}, 64'h0);
        while (cyc < 320) begin
            tick();
            check_scan(FR_B, 1'b0);
        end
        tick();
        chk("late_swap", {63'h0, sw1}, 64'h1);
        chk("late_col_new", {56'h0, col1}, {56'h0, FR_C[7:0]});
        $display("late accept: C visible cyc=%0d col=%0h", cyc, col1);

        // Wrap and repeat: three frame periods with no new frame
        while (cyc < 455) begin
            tick();
            check_scan(FR_C, 1'b1);
        end
        $display("wrap/repeat done at cyc=%0d", cyc);

        // Park a frame in pending, then reset in the middle of row 3 drive
        bus1.pix = FR_Z;
        bus1.frame_valid = 1'b1;
        tick();
        bus1.frame_valid = 1'b0;
        check_scan(FR_C, 1'b0);
        tick();
        check_scan(FR_C, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_row_sel", {56'h0, rs1}, 64'h0);
        chk("async_col", {56'h0, col1}, 64'h0);
        chk("async_row_idx", {61'h0, idx1}, 64'h0);
        chk("async_swap", {63'h0, sw1}, 64'h0);
        chk("async_ready", {63'h0, bus1.frame_ready}, 64'h1);
        $display("async reset mid-row3: row_sel=%0h col=%0h ready=%0b", rs1, col1, bus1.frame_ready);
        tick();

        // DWELL=1, BLANK=1: 16-cycle frame. The pending frame was discarded by reset.
        rst_n = 1'b1;
        cyc = 0;
        bus2.pix = FR_E;
        bus2.frame_valid = 1'b1;
        tick();
        bus2.frame_valid = 1'b0;
        check_scan2(64'h0, 1'b0);
        while (cyc < 16) begin
            tick();
            check_scan2(64'h0, 1'b0);
        end
        tick();
        chk("fast_first_swap", {63'h0, sw2}, 64'h1);
        chk("fast_first_col", {56'h0, col2}, {56'h0, FR_E[7:0]});
        chk("fast_first_ready", {63'h0, bus2.frame_ready}, 64'h1);
        $display("fast instance: E visible cyc=%0d col=%0h", cyc, col2);
        while (cyc < 48) begin
            tick();
            check_scan2(FR_E, 1'b1);
            if (cyc == 41) begin
                chk("discard_swap", {63'h0, sw1}, 64'h0);
                chk("discard_col", {56'h0, col1}, 64'h0);
                chk("discard_row_sel", {56'h0, rs1}, 64'h01);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
